mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data RAM port: turns CPU load/store requests (byte/half/word,
//  signed/unsigned) into RAM accesses. Drives the word-wide, synchronous-read RAM.
//  Does lane select, sign/zero extension, misalignment detection and sub-word stores
//  via read-modify-write. Sits between the execute stage and the data RAM.
// PARAMETERS
//  ADDR_W  `RAM_ADDRESS_BITWIDTH  byte-address width; RAM word index = addr[ADDR_W-1:2]
// PORTS
//  clk             in   1       clock; all state on posedge
//  rstn            in   1       asynchronous, active-low reset
//  req_valid       in   1       request present
//  req_ready       out  1       unit can accept (high only in IDLE, gated by rstn)
//  req_we          in   1       1=store, 0=load
//  req_size        in   2       0=byte, 1=half, 2=word, 3=illegal (misaligned)
//  req_signed      in   1       load only: 1=sign-extend, 0=zero-extend
//  req_addr        in   ADDR_W  byte address
//  req_wdata       in   32      store data, right-justified
//  resp_valid      out  1       one-cycle completion pulse, no backpressure
//  resp_rdata      out  32      load result (0 for stores / errors)
//  resp_misaligned out  1       valid with resp_valid; access rejected
//  ram_wren        out  1       RAM write enable (commits at posedge)
//  ram_address     out  ADDR_W  RAM byte address; bits [1:0] driven from request, ignored by RAM
//  ram_write_data  out  32      full word to write
//  ram_data        in   32      RAM read data, valid the cycle after the address is sampled
// BEHAVIOUR
//  Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_misaligned=0, latched req regs=0;
//   ram_wren=0 while rstn low. Reset mid-RMW aborts the write; memory is unchanged.
//  Accept = req_valid & req_ready at a posedge (edge T0). In IDLE the ram_* outputs are
//   combinational from req_*, so the RAM samples the address and write at T0.
//  Misaligned: size==3 | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0).
//   No RAM access (ram_wren=0). resp_valid=1, resp_misaligned=1, resp_rdata=0 in cycle after T0.
//  Word store: ram_wren=1 at accept; resp_valid in cycle after T0 (latency 1).
//  Load: IDLE->LOAD at T0. In LOAD, ram_data is valid; extract and extend it.
//   Register the result at T1 and ->IDLE; resp_valid in cycle after T1 (latency 2).
//  Sub-word store: IDLE->RMW at T0 (read issued, ram_wren=0).
//   In RMW: ram_address=latched addr, ram_write_data=merge(ram_data, wdata), ram_wren=1.
//   Write commits at T1, ->IDLE; resp_valid in cycle after T1 (latency 2).
//  Lanes little-endian: byte k = bits[8k+7:8k], k=addr[1:0]; half h = bits[16h+15:16h],
//   h=addr[1]. Merge replaces only the addressed lane(s); the other bytes come from ram_data.
//  Extension: signed fills upper bits with lane MSB, unsigned with 0. Word ignores req_signed.
//  resp_valid is a pulse. req_ready is 1 in the same cycle (state is IDLE), so back-to-back
//   accept is allowed; a load after a store to the same word sees the new data.
//  Outside IDLE: req_ready=0; req_* are ignored. resp_* are held at their last value
//   except resp_valid, which is low.
// STRUCTURE
//  Shared package/define.sv: SIZE_BYTE/HALF/WORD encodings and the state enum
//   {IDLE, LOAD, RMW}. The RAM width/size defines stay in define.sv.
//  Sub-module mem_lane_align (combinational): extract+extend for loads and
//   lane merge for stores. The FSM and registers stay in the top.
// TESTING (bench pairs the unit with the data RAM model)
//  1 rstn low during RMW cycle -> ram_wren=0 immediately, word unchanged; after release
//    req_ready=1, resp_valid=0.
//  2 word store 0xDEADBEEF @0x10 -> resp_valid 1 cycle later; word load @0x10 ->
//    resp_rdata=0xDEADBEEF, 2 cycles after accept.
//  3 word @0x10=0x11223344; byte store 0xAA @0x13 -> word 0xAA223344;
//    signed byte load @0x13 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
//  4 word=0x11223344; half store 0x8001 @0x12 -> 0x80013344;
//    signed half load @0x12 -> 0xFFFF8001; unsigned @0x10 -> 0x00003344.
//  5 word store @0x11, half load @0x13, size=3 -> resp_misaligned=1, rdata=0, latency 1,
//    ram_wren never asserted.
//  6 req_valid held high across 4 mixed requests -> each accepted in its resp cycle;
//    no dropped/duplicated resp_valid; store-then-load same word returns stored data.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data RAM access unit: RAM geometry, request size codes,
// controller states and the alignment rule.
package mem_access_unit_pkg;

  localparam int unsigned RAM_ADDRESS_BITWIDTH = 12;
  localparam int unsigned RAM_DATA_BITWIDTH    = 32;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RMW  = 2'd2
  } mau_state_e;

  // An access is rejected when its size is illegal or its address is not a
  // multiple of the access width.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (size)
      SIZE_HALF:    r = addr_lo[0];
      SIZE_WORD:    r = (addr_lo != 2'd0);
      SIZE_ILLEGAL: r = 1'b1;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: extracts and extends the addressed lane of a RAM
// word for loads, and merges sub-word store data into the RAM word for RMW.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_ram_data,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction (little-endian) with sign or zero extension.
  always_comb begin
    w_byte = '0;
    w_half = '0;
    o_load_data = i_ram_data;
    case (i_addr_lo)
      2'd0:    w_byte = i_ram_data[7:0];
      2'd1:    w_byte = i_ram_data[15:8];
      2'd2:    w_byte = i_ram_data[23:16];
      default: w_byte = i_ram_data[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_ram_data[31:16] : i_ram_data[15:0];
    case (i_size)
      SIZE_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      default:   o_load_data = i_ram_data;
    endcase
  end

  // Store merge: only the addressed lane(s) take store data.
  always_comb begin
    o_merge_data = i_ram_data;
    case (i_size)
      SIZE_BYTE: begin
        case (i_addr_lo)
          2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
          2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data[23:16] = i_wdata[7:0];
          default: o_merge_data[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (i_addr_lo[1]) o_merge_data[31:16] = i_wdata[15:0];
        else              o_merge_data[15:0]  = i_wdata[15:0];
      end
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide, synchronous-read data RAM.
// Word stores and rejected accesses complete in one cycle; loads and sub-word
// stores (read-modify-write) take a second cycle for the RAM read data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDRESS_BITWIDTH
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_data
);

  mau_state_e        r_state;
  mau_state_e        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic              w_accept;
  logic              w_misaligned;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;

  assign req_ready    = (r_state == ST_IDLE) & rstn;
  assign w_accept     = req_valid & req_ready;
  assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);

  mem_lane_align u_align (
    .i_ram_data   (ram_data),
    .i_wdata      (r_wdata),
    .i_addr_lo    (r_addr[1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and RAM port drive. In IDLE the RAM sees the request directly so
  // the access starts at the accept edge; later states use the latched request.
  always_comb begin
    w_state_next   = r_state;
    ram_wren       = 1'b0;
    ram_address    = req_addr;
    ram_write_data = req_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_misaligned) begin
          if (req_we && (req_size == SIZE_WORD)) ram_wren = 1'b1;
          else if (req_we)                       w_state_next = ST_RMW;
          else                                   w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ram_address  = r_addr;
        w_state_next = ST_IDLE;
      end
      ST_RMW: begin
        ram_address    = r_addr;
        ram_write_data = w_merge_data;
        ram_wren       = rstn;
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request latch for the two-cycle operations.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
    end
  end

  // Response registers: single-cycle valid pulse, data/flag held between responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              resp_valid      <= 1'b1;
              resp_rdata      <= '0;
              resp_misaligned <= 1'b1;
            end else if (req_we && (req_size == SIZE_WORD)) begin
              resp_valid      <= 1'b1;
              resp_rdata      <= '0;
              resp_misaligned <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          resp_valid      <= 1'b1;
          resp_rdata      <= w_load_data;
          resp_misaligned <= 1'b0;
        end
        ST_RMW: begin
          resp_valid      <= 1'b1;
          resp_rdata      <= '0;
          resp_misaligned <= 1'b0;
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit paired with a synchronous-read word RAM model.
// Stimulus pushes expected responses; a monitor pops them on resp_valid.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_write_data;
  logic [31:0]   ram_data = '0;

  logic [31:0] mem [0:(1<<(AW-2))-1];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   seen = 0;
  logic wren_seen = 1'b0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .ram_wren        (ram_wren),
    .ram_address     (ram_address),
    .ram_write_data  (ram_write_data),
    .ram_data        (ram_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren) begin
      mem[ram_address[AW-1:2]] <= ram_write_data;
      wren_seen <= 1'b1;
    end
    ram_data <= mem[ram_address[AW-1:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata=%h mis=%0d expected none", resp_rdata, resp_misaligned);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives one request from a falling edge until it is accepted at a rising edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic em, input int lat, input logic chk);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end else if (chk) begin
      e.rdata = er;
      e.mis   = em;
      e.cyc   = cyc + lat;
      exp_q.push_back(e);
      pushed++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state, with a word store pending on the inputs.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SIZE_WORD;
    req_addr  = 12'h010;
    repeat (2) @(negedge clk);
    check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_mis", {31'd0, resp_misaligned}, 32'd0);
    req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Reset during RMW aborts the write.
    issue(1, SIZE_WORD, 0, 12'h020, 32'h11223344, 32'h0, 0, 1, 1);
    issue(1, SIZE_BYTE, 0, 12'h020, 32'h00000055, 32'h0, 0, 2, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_wren", {31'd0, ram_wren}, 32'd1);
    rstn = 1'b0;
    #1;
    check("rmw_rst_wren", {31'd0, ram_wren}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    check("rmw_rst_valid", {31'd0, resp_valid}, 32'd0);
    issue(0, SIZE_WORD, 0, 12'h020, 32'h0, 32'h11223344, 0, 2, 1);
    idle(3);

    // Word store then word load.
    issue(1, SIZE_WORD, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0, 1, 1);
    idle(2);
    issue(0, SIZE_WORD, 1, 12'h010, 32'h0, 32'hDEADBEEF, 0, 2, 1);
    idle(3);

    // Byte store via RMW; signed/unsigned byte loads.
    issue(1, SIZE_WORD, 0, 12'h010, 32'h11223344, 32'h0, 0, 1, 1);
    issue(1, SIZE_BYTE, 0, 12'h013, 32'h123456AA, 32'h0, 0, 2, 1);
    issue(0, SIZE_WORD, 0, 12'h010, 32'h0, 32'hAA223344, 0, 2, 1);
    issue(0, SIZE_BYTE, 1, 12'h013, 32'h0, 32'hFFFFFFAA, 0, 2, 1);
    issue(0, SIZE_BYTE, 0, 12'h013, 32'h0, 32'h000000AA, 0, 2, 1);
    issue(0, SIZE_BYTE, 1, 12'h011, 32'h0, 32'h00000033, 0, 2, 1);
    idle(3);

    // Half store via RMW; half loads.
    issue(1, SIZE_WORD, 0, 12'h010, 32'h11223344, 32'h0, 0, 1, 1);
    issue(1, SIZE_HALF, 0, 12'h012, 32'hFFFF8001, 32'h0, 0, 2, 1);
    issue(0, SIZE_WORD, 0, 12'h010, 32'h0, 32'h80013344, 0, 2, 1);
    issue(0, SIZE_HALF, 1, 12'h012, 32'h0, 32'hFFFF8001, 0, 2, 1);
    issue(0, SIZE_HALF, 0, 12'h010, 32'h0, 32'h00003344, 0, 2, 1);
    idle(3);

    // Misaligned and illegal-size requests never touch the RAM.
    wren_seen = 1'b0;
    issue(1, SIZE_WORD, 0, 12'h011, 32'h99999999, 32'h0, 1, 1, 1);
    issue(0, SIZE_HALF, 1, 12'h013, 32'h0, 32'h0, 1, 1, 1);
    issue(0, SIZE_ILLEGAL, 0, 12'h010, 32'h0, 32'h0, 1, 1, 1);
    issue(1, SIZE_ILLEGAL, 0, 12'h014, 32'h77777777, 32'h0, 1, 1, 1);
    idle(3);
    check("mis_no_wren", {31'd0, wren_seen}, 32'd0);
    issue(0, SIZE_WORD, 0, 12'h010, 32'h0, 32'h80013344, 0, 2, 1);
    idle(3);

    // Back-to-back mixed requests with req_valid held high.
    issue(1, SIZE_WORD, 0, 12'h040, 32'hCAFEF00D, 32'h0, 0, 1, 1);
    issue(0, SIZE_WORD, 0, 12'h040, 32'h0, 32'hCAFEF00D, 0, 2, 1);
    issue(1, SIZE_BYTE, 0, 12'h041, 32'h00000077, 32'h0, 0, 2, 1);
    issue(0, SIZE_HALF, 0, 12'h040, 32'h0, 32'h0000770D, 0, 2, 1);
    idle(1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    idle(3);
    check("queue_drained", exp_q.size(), 32'd0);
    check("resp_count", seen, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
